// File: rtl/vecadd_unit_if.sv
// Execute-stage handshake between the instruction decoder and the packed-lane vector adder.
interface vecadd_unit_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANE_W = 8
);
    localparam int unsigned LANES = WIDTH / LANE_W;

    logic             Start;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Stall;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [LANES-1:0] CarryMask;

    modport master (
        output Start, SrcA, SrcB,
        input  Stall, Busy, Done, Result, CarryMask
    );

    modport slave (
        input  Start, SrcA, SrcB,
        output Stall, Busy, Done, Result, CarryMask
    );
endinterface

// File: rtl/vecadd_unit.sv
// Multi-cycle packed-lane adder, one lane per cycle LSB first; stalls fetch until the sum is written back.
// Build option: define VECADD_SAT_EN for unsigned saturating lanes (default build wraps).
module vecadd_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    vecadd_unit_if.slave  bus
);
    localparam int unsigned LANES = WIDTH / LANE_W;
    localparam int unsigned CW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [LANES-1:0]  cmask_q, cmask_d;
    logic              done_q, done_d;
    int unsigned       lane_base;
    logic [LANE_W:0]   lane_sum;
    logic [LANE_W-1:0] lane_val;

    // Current lane sum from the latched operands only; lanes never chain carries.
    always_comb begin
        lane_base = 32'(cnt_q) * LANE_W;
        lane_sum  = {1'b0, opa_q[lane_base +: LANE_W]} + {1'b0, opb_q[lane_base +: LANE_W]};
`ifdef VECADD_SAT_EN
        lane_val  = lane_sum[LANE_W] ? {LANE_W{1'b1}} : lane_sum[LANE_W-1:0];
`else
        lane_val  = lane_sum[LANE_W-1:0];
`endif
    end

    // Next-state and datapath updates; Start is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cmask_d  = cmask_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    opa_d    = bus.SrcA;
                    opb_d    = bus.SrcB;
                    result_d = '0;
                    cmask_d  = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[lane_base +: LANE_W] = lane_val;
                cmask_d[cnt_q]                = lane_sum[LANE_W];
                if (cnt_q == CW'(LANES - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cmask_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cmask_q  <= cmask_d;
            done_q   <= done_d;
        end
    end

    // Stall drops in DONE so the PC advances on the writeback edge.
    assign bus.Stall     = ((state_q == IDLE) && bus.Start) || (state_q == RUN);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.Result    = result_q;
    assign bus.CarryMask = cmask_q;
endmodule
